// File: rtl/pattern_sequencer.sv
// LED pattern sequencer: a power-of-two prescaler paces chase, bounce, binary
// and gray-code patterns, with hold/single-step control and tick/wrap pulses.
module pattern_sequencer #(
    parameter int WIDTH      = 8,
    parameter int SPEED_W    = 3,
    parameter int BASE_SHIFT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SPEED_W-1:0] speed,
    input  logic [1:0]         mode,
    input  logic               hold,
    input  logic               step,
    output logic [WIDTH-1:0]   pattern,
    output logic               tick,
    output logic               wrap
);

    localparam int PRE_W = BASE_SHIFT + (1 << SPEED_W);

    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
    localparam logic [WIDTH-1:0] PAT_ONE = WIDTH'(1);

    localparam logic [1:0] MODE_CHASE  = 2'b00;
    localparam logic [1:0] MODE_BOUNCE = 2'b01;
    localparam logic [1:0] MODE_BIN    = 2'b10;
    localparam logic [1:0] MODE_GRAY   = 2'b11;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    logic [WIDTH-1:0]   cnt;
    logic [PRE_W-1:0]   pre;
    logic [1:0]         mode_q;
    logic [SPEED_W-1:0] speed_q;
    logic               step_q;
    dir_t               dir;

    logic [WIDTH-1:0]   pattern_nxt;
    logic [WIDTH-1:0]   cnt_nxt;
    logic [WIDTH-1:0]   cnt_inc;
    logic [PRE_W-1:0]   pre_nxt;
    dir_t               dir_nxt;
    logic               tick_nxt;
    logic               wrap_nxt;
    logic               adv;

    // Prescaler terminal count: a reload of 2^k-1 gives one advance per 2^k clocks.
    function automatic logic [PRE_W-1:0] reload(input logic [SPEED_W-1:0] s);
        return (PRE_ONE << (BASE_SHIFT + int'(s))) - PRE_ONE;
    endfunction

    // Counting modes start from all-zero, one-hot modes from bit 0.
    function automatic logic [WIDTH-1:0] init_pattern(input logic [1:0] m);
        return m[1] ? '0 : PAT_ONE;
    endfunction

    // Advance request: free-running prescaler, or step edge while held.
    always_comb begin
        adv     = 1'b0;
        pre_nxt = pre;
        if (hold) begin
            adv = step & ~step_q;
        end else if (pre == '0) begin
            adv     = 1'b1;
            pre_nxt = reload(speed_q);
        end else begin
            pre_nxt = pre - PRE_ONE;
        end

        cnt_inc     = cnt + PAT_ONE;
        pattern_nxt = pattern;
        cnt_nxt     = cnt;
        dir_nxt     = dir;
        tick_nxt    = 1'b0;
        wrap_nxt    = 1'b0;

        if (mode != mode_q) begin
            pattern_nxt = init_pattern(mode);
            cnt_nxt     = '0;
            dir_nxt     = DIR_LEFT;
            pre_nxt     = reload(speed);
        end else if (speed != speed_q) begin
            pre_nxt = reload(speed);
        end else if (adv) begin
            tick_nxt = 1'b1;
            case (mode_q)
                MODE_CHASE: begin
                    pattern_nxt = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
                    wrap_nxt    = pattern[WIDTH-1];
                end
                MODE_BOUNCE: begin
                    if (dir == DIR_LEFT) begin
                        pattern_nxt = {pattern[WIDTH-2:0], 1'b0};
                        if (pattern_nxt[WIDTH-1])
                            dir_nxt = DIR_RIGHT;
                    end else begin
                        pattern_nxt = {1'b0, pattern[WIDTH-1:1]};
                        if (pattern_nxt[0]) begin
                            dir_nxt  = DIR_LEFT;
                            wrap_nxt = 1'b1;
                        end
                    end
                end
                MODE_BIN: begin
                    cnt_nxt     = cnt_inc;
                    pattern_nxt = cnt_inc;
                    wrap_nxt    = &cnt;
                end
                MODE_GRAY: begin
                    cnt_nxt     = cnt_inc;
                    pattern_nxt = cnt_inc ^ (cnt_inc >> 1);
                    wrap_nxt    = &cnt;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern <= init_pattern(mode);
            cnt     <= '0;
            dir     <= DIR_LEFT;
            tick    <= 1'b0;
            wrap    <= 1'b0;
            step_q  <= 1'b0;
            pre     <= reload(speed);
            mode_q  <= mode;
            speed_q <= speed;
        end else begin
            pattern <= pattern_nxt;
            cnt     <= cnt_nxt;
            dir     <= dir_nxt;
            tick    <= tick_nxt;
            wrap    <= wrap_nxt;
            step_q  <= step;
            pre     <= pre_nxt;
            mode_q  <= mode;
            speed_q <= speed;
        end
    end

endmodule
